// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// input capture, saturation on overflow and a leading-zero blank mask.

module bin2bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin2bcd_seq #(
  parameter int N      = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);
  localparam int CW = $clog2(N+1);
  localparam int BW = 4*DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state, state_nxt;
  logic [N-1:0]             shreg;
  logic [DIGITS-1:0][3:0]   scratch, scratch_adj;
  logic [BW-1:0]            adj_flat;
  logic                     sticky;
  logic [CW-1:0]            cnt;
  logic                     load, step, publish;
  logic [DIGITS-1:0][3:0]   bcd_nxt;
  logic [DIGITS-1:0]        blank_nxt;
  logic                     all_zero;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bin2bcd_digit_adj u_adj (.din(scratch[g]), .dout(scratch_adj[g]));
    end
  endgenerate

  assign adj_flat = scratch_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    load    = (state == IDLE) && start;
    step    = (state == SHIFT);
    publish = (state == DONE);
  end

  // The bit leaving the top of the scratch is set only when the top digit
  // was >= 5 before doubling, i.e. the value no longer fits in DIGITS digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      shreg   <= binary;
      scratch <= '0;
      sticky  <= 1'b0;
      cnt     <= CW'(N);
    end else if (step) begin
      shreg   <= shreg << 1;
      scratch <= {adj_flat[BW-2:0], shreg[N-1]};
      sticky  <= sticky | adj_flat[BW-1];
      cnt     <= cnt - CW'(1);
    end
  end

  always_comb begin
    bcd_nxt   = sticky ? {DIGITS{4'h9}} : scratch;
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      all_zero     = all_zero & (bcd_nxt[i] == 4'd0);
      blank_nxt[i] = all_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      blank_mask <= BLANK_RST;
    end else begin
      done <= publish;
      if (publish) begin
        bcd        <= bcd_nxt;
        overflow   <= sticky;
        blank_mask <= blank_nxt;
      end
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double dabble) algorithm, one bit per clock, with a start/busy/done handshake. It replaces the combinational 20-bit/6-digit converter on the display path. It adds three things that converter lacks:
- saturation with an overflow flag when the value does not fit in DIGITS decimal digits;
- a leading-zero blank mask for the seven-segment driver;
- input capture, so the source may change while a conversion runs.

## Interface
- N, 20, binary input width (≥1)
- DIGITS, 6, number of BCD output digits (≥1); digit 0 is least significant, in bcd[3:0]
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- binary  input  N  value to convert; captured on the accepted start edge only
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle registered pulse; outputs valid and updated
- bcd  output  4*DIGITS  converted value, held until next done
- overflow  output  1  value ≥ 10^DIGITS; held with bcd
- blank_mask  output  DIGITS  bit i = 1 when digit i and every higher digit are 0; bit 0 always 0

## Operation
- Internal registers:
  - shift register, N bits;
  - BCD scratch, 4*DIGITS bits;
  - sticky overflow bit;
  - bit counter, $clog2(N+1) bits;
  - state: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - load shift register ← binary;
  - clear scratch and sticky bit;
  - counter ← N;
  - → SHIFT.
- IDLE, start=0: hold.
- SHIFT, each cycle, in this order:
  - Correct: every scratch digit ≥5 gets +3 (4-bit, no carry between digits).
  - Shift: {scratch, shift register} shifts left by one.
  - Overflow: the bit leaving scratch MSB ORs into the sticky bit.
  - Counter decrements.
  - On the cycle the counter goes 1→0, → DONE.
- DONE, one cycle:
  - Load outputs:
    - overflow ← sticky bit;
    - bcd ← scratch if sticky=0, else all digits 4'h9 (saturate);
    - blank_mask computed from the loaded bcd value.
  - done ← 1; → IDLE.
- start while busy=1 is ignored and not queued. Changes on binary after the accepted edge have no effect.
- blank_mask, bit i:
  - i ≥ 1: 1 when bcd digits i..DIGITS-1 are all zero;
  - i = 0: always 0, so one "0" digit is always shown.
- Reset, asynchronous, effective immediately including mid-conversion:
  - state IDLE, busy 0, done 0;
  - bcd 0, overflow 0;
  - blank_mask = {DIGITS-1 ones, 0};
  - internal registers cleared.
  - A conversion interrupted by reset produces no done pulse.
- After rst deasserts, the first rising edge with start=1 is accepted.

## Timing
- Let edge k be the edge at which start=1 is sampled in IDLE.
- Edge k: capture; busy high from k.
- Edges k+1 … k+N: N shift steps; state = DONE after edge k+N.
- Edge k+N+1:
  - bcd, overflow, blank_mask update;
  - done rises;
  - busy falls;
  - state IDLE.
- Edge k+N+2: done falls. start sampled at this edge is accepted (back-to-back).
- Throughput: one conversion per N+2 cycles.
- Latency from the start edge to done high: N+1 cycles.
- Outputs change only at the DONE edge or on reset; they are stable otherwise.
- N=1 is legal: one shift cycle, done at k+2.

## Test plan
- Reset, then binary=0, start pulse:
  - done exactly at k+21 (N=20);
  - bcd=24'h000000, overflow=0, blank_mask=6'b111110;
  - busy high for exactly 21 cycles.
- binary=123456:
  - bcd=24'h123456, overflow=0, blank_mask=6'b000000.
  - Drive binary=7 on the cycle after start: the result is unchanged.
- binary=999999:
  - bcd=24'h999999, overflow=0.
- binary=1000000:
  - overflow=1, bcd=24'h999999, blank_mask=0.
- binary=1048575 (max):
  - overflow=1, bcd=24'h999999.
- binary=42:
  - bcd=24'h000042, blank_mask=6'b111100.
  - Pulse start at k+5: ignored, exactly one done.
- Back-to-back: start held high continuously → done every 22 cycles.
- Reset mid-conversion:
  - assert rst at k+10: busy=0 and bcd=0 immediately, no done pulse.
  - Then convert 5: bcd=24'h000005.
- Sweep binary 0…2^20-1 (random subset) against a reference model.
- Re-run the sweep with N=8, DIGITS=3 and N=4, DIGITS=1 (9 → 4'h9; 10 → overflow).
